// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters and the memory.
// slave: arbiter view (requests in, responses/memory strobes out); master: environment view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_done;
    logic              if_stall;
    logic              dm_req;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              dm_stall;
    logic              halt_req;
    logic              dump;
    logic              halted;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata,
        input  halt_req, mem_rdata, mem_done,
        output if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall,
        output dump, halted, mem_en, mem_wr, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata,
        output halt_req, mem_rdata, mem_done,
        input  if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall,
        input  dump, halted, mem_en, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and the data stage, one transaction at a time,
// and sequences halt -> dump -> halted. Ports: clk, rst (sync, active-high), bus (slave side).
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_LIM = 2
) (
    input logic        clk,
    input logic        rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, RESP, DUMP, HALTED
    } state_t;

    state_t            state_q, state_d;
    logic              own_dm_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic [CNT_W-1:0]  wait_q;
    logic [STV_W-1:0]  starve_q;
    logic              err_q;

    logic              grant_if, grant_dm;
    logic              fetch_over;
    logic              timeout;
    logic              finish;
    logic [DATA_W-1:0] resp_data;

    // Fetch overrides data once data has won STARVE_LIM times in a row, unless a halt is pending.
    assign fetch_over = (starve_q == STV_W'(STARVE_LIM)) && bus.if_req && !bus.halt_req;
    // Counter reads k-1 in the k-th WAIT cycle, so MAX_WAIT full WAIT cycles pass before giving up.
    assign timeout    = !bus.mem_done && (wait_q == CNT_W'(MAX_WAIT - 1));
    assign finish     = (state_q == WAIT) && (bus.mem_done || timeout);
    assign resp_data  = bus.mem_done ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        grant_if      = 1'b0;
        grant_dm      = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.if_done   = 1'b0;
        bus.dm_done   = 1'b0;
        bus.dump      = 1'b0;
        bus.halted    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_over) begin
                    grant_if = 1'b1;
                    state_d  = ISSUE;
                end else if (bus.dm_req) begin
                    grant_dm = 1'b1;
                    state_d  = ISSUE;
                end else if (bus.halt_req) begin
                    state_d  = DUMP;
                end else if (bus.if_req) begin
                    grant_if = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_wr = wr_q;
                state_d    = WAIT;
            end
            WAIT: begin
                if (finish) state_d = RESP;
            end
            RESP: begin
                bus.if_done = !own_dm_q;
                bus.dm_done = own_dm_q;
                state_d     = IDLE;
            end
            DUMP: begin
                bus.dump = 1'b1;
                state_d  = HALTED;
            end
            HALTED: begin
                bus.halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_dm_q   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
            wait_q     <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (grant_if || grant_dm) begin
                own_dm_q <= grant_dm;
                wr_q     <= grant_dm && bus.dm_wr;
                addr_q   <= grant_dm ? bus.dm_addr : bus.if_addr;
                wdata_q  <= grant_dm ? bus.dm_wdata : '0;
            end
            if (state_q == ISSUE)     wait_q <= '0;
            else if (state_q == WAIT) wait_q <= wait_q + CNT_W'(1);
            if (finish) begin
                if (!own_dm_q)  if_data_q  <= resp_data;
                else if (!wr_q) dm_rdata_q <= resp_data;
                if (!bus.mem_done) err_q <= 1'b1;
            end
            if (!bus.if_req || grant_if)
                starve_q <= '0;
            else if (grant_dm && starve_q != STV_W'(STARVE_LIM))
                starve_q <= starve_q + STV_W'(1);
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_data   = if_data_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.if_stall  = bus.if_req & ~bus.if_done;
    assign bus.dm_stall  = bus.dm_req & ~bus.dm_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester agents, a memory model and a scoreboard
// of expected memory operations and responses.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MAX_WAIT = 15;
    localparam int STARVE_LIM = 2;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } op_t;

    typedef struct {
        logic        dm;
        logic        wr;
        logic [15:0] data;
        logic        to;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    op_t         exp_ops[$];
    rsp_t        exp_rsp[$];
    op_t         dm_cmd[$];
    logic [15:0] if_cmd[$];
    logic [15:0] mem [0:255];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cyc = -100;
    int   en_count = 0;
    int   dump_count = 0;
    int   dump_cyc = -1;
    int   dm_done_cyc = -1;
    int   mem_lat = 1;
    bit   mute = 0;
    bit   stray = 0;
    bit   to_armed = 0;
    bit   if_busy = 0;
    bit   dm_busy = 0;
    logic err_prev = 1'b0;
    logic [15:0] model_dm = 16'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Scoreboard / monitor: samples 1 time unit after each rising edge.
    always begin
        op_t         op;
        rsp_t        r;
        logic [15:0] got, want;
        int          want_c;
        @(posedge clk);
        cyc++;
        #1;
        if (!rst) begin
            chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~bus.if_done));
            chk("dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req & ~bus.dm_done));
            if (bus.mem_en === 1'b1) begin
                en_count++;
                checks++;
                assert (exp_ops.size() > 0 && bus.halted !== 1'b1) else begin
                    errors++;
                    $error("FAIL mem_en_unexpected: got addr %h want none", bus.mem_addr);
                end
                if (exp_ops.size() > 0) begin
                    op = exp_ops.pop_front();
                    chk("mem_op", {15'h0, bus.mem_wr, bus.mem_addr}, {15'h0, op.wr, op.addr});
                    if (op.wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(op.wdata));
                end
                en_cyc = cyc;
            end
            if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) begin
                checks++;
                assert (!(bus.if_done && bus.dm_done) && exp_rsp.size() > 0) else begin
                    errors++;
                    $error("FAIL done_unexpected: got if %b dm %b want none", bus.if_done, bus.dm_done);
                end
                if (exp_rsp.size() > 0) begin
                    r = exp_rsp.pop_front();
                    chk("done_owner", 32'(bus.dm_done), 32'(r.dm));
                    got  = r.dm ? bus.dm_rdata : bus.if_data;
                    want = (r.dm && r.wr) ? model_dm : r.data;
                    chk("done_data", 32'(got), 32'(want));
                    if (r.dm && !r.wr) model_dm = r.data;
                    want_c = r.to ? en_cyc + MAX_WAIT + 1 : en_cyc + mem_lat + 1;
                    chk("done_cycle", 32'(cyc), 32'(want_c));
                end
                if (bus.dm_done === 1'b1) dm_done_cyc = cyc;
            end
            if (bus.err === 1'b1 && err_prev !== 1'b1) begin
                chk("err_rise_cycle", 32'(cyc), 32'(en_cyc + MAX_WAIT + 1));
                chk("err_rise_armed", 32'(to_armed), 32'd1);
            end
            if (bus.dump === 1'b1) begin
                dump_count++;
                dump_cyc = cyc;
            end
        end
        err_prev = bus.err;
    end

    // Memory model: answers mem_en after mem_lat cycles unless muted.
    initial begin
        int          resp_cnt;
        logic [15:0] rd_val;
        resp_cnt = 0;
        rd_val = 16'h0;
        bus.mem_done = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            bus.mem_done = stray;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bus.mem_done = 1'b1;
                    bus.mem_rdata = rd_val;
                end
            end
            if (bus.mem_en === 1'b1 && !mute) begin
                if (bus.mem_wr) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
                rd_val = mem[bus.mem_addr[7:0]];
                resp_cnt = mem_lat;
            end
        end
    end

    // Fetch agent: holds if_req until if_done, then moves to the next address.
    initial begin
        forever begin
            @(negedge clk);
            if (if_busy && bus.if_done === 1'b1) begin
                if_busy = 0;
                bus.if_req = 1'b0;
            end
            if (!if_busy && if_cmd.size() > 0) begin
                bus.if_addr = if_cmd.pop_front();
                bus.if_req = 1'b1;
                if_busy = 1;
            end
        end
    end

    // Data agent: same protocol for loads/stores.
    initial begin
        op_t op;
        forever begin
            @(negedge clk);
            if (dm_busy && bus.dm_done === 1'b1) begin
                dm_busy = 0;
                bus.dm_req = 1'b0;
            end
            if (!dm_busy && dm_cmd.size() > 0) begin
                op = dm_cmd.pop_front();
                bus.dm_wr = op.wr;
                bus.dm_addr = op.addr;
                bus.dm_wdata = op.wdata;
                bus.dm_req = 1'b1;
                dm_busy = 1;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            sync();
            if (exp_rsp.size() == 0 && exp_ops.size() == 0 && if_cmd.size() == 0 &&
                dm_cmd.size() == 0 && !if_busy && !dm_busy) begin
                ok = 1;
                break;
            end
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s: got pending %0d want 0 within %0d cycles", tag, exp_rsp.size(), budget);
        end
    endtask

    task automatic flush_agents();
        if_cmd.delete();
        dm_cmd.delete();
        exp_ops.delete();
        exp_rsp.delete();
        if_busy = 0;
        dm_busy = 0;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem"}, {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 32'h0);
        chk({tag, "_data"}, {bus.if_data, bus.dm_rdata}, 32'h0);
        chk({tag, "_flags"}, 32'({bus.if_done, bus.dm_done, bus.dump, bus.halted, bus.err}), 32'h0);
    endtask

    initial begin
        int c0;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257);
        mem[8'h10] = 16'hC0DE;
        bus.if_req = 1'b0;
        bus.if_addr = 16'h0;
        bus.dm_req = 1'b0;
        bus.dm_wr = 1'b0;
        bus.dm_addr = 16'h0;
        bus.dm_wdata = 16'h0;
        bus.halt_req = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Lone fetch, memory answers two cycles after mem_en.
        sync();
        mem_lat = 2;
        exp_ops.push_back('{1'b0, 16'h0010, 16'h0});
        exp_rsp.push_back('{1'b0, 1'b0, 16'hC0DE, 1'b0});
        if_cmd.push_back(16'h0010);
        drain("lone_fetch", 60);
        mem_lat = 1;

        // Store and fetch rise together: store first, fetch reads it back.
        sync();
        exp_ops.push_back('{1'b1, 16'h0020, 16'h1234});
        exp_ops.push_back('{1'b0, 16'h0020, 16'h0});
        exp_rsp.push_back('{1'b1, 1'b1, 16'h0, 1'b0});
        exp_rsp.push_back('{1'b0, 1'b0, 16'h1234, 1'b0});
        dm_cmd.push_back('{1'b1, 16'h0020, 16'h1234});
        if_cmd.push_back(16'h0020);
        drain("conflict", 60);

        // Starvation: D, D, I, D, D, I.
        sync();
        exp_ops.push_back('{1'b1, 16'h0040, 16'hAAAA});
        exp_ops.push_back('{1'b0, 16'h0040, 16'h0});
        exp_ops.push_back('{1'b0, 16'h0050, 16'h0});
        exp_ops.push_back('{1'b1, 16'h0041, 16'hBBBB});
        exp_ops.push_back('{1'b0, 16'h0041, 16'h0});
        exp_ops.push_back('{1'b0, 16'h0052, 16'h0});
        exp_rsp.push_back('{1'b1, 1'b1, 16'h0, 1'b0});
        exp_rsp.push_back('{1'b1, 1'b0, 16'hAAAA, 1'b0});
        exp_rsp.push_back('{1'b0, 1'b0, 16'h5050, 1'b0});
        exp_rsp.push_back('{1'b1, 1'b1, 16'h0, 1'b0});
        exp_rsp.push_back('{1'b1, 1'b0, 16'hBBBB, 1'b0});
        exp_rsp.push_back('{1'b0, 1'b0, 16'h5252, 1'b0});
        dm_cmd.push_back('{1'b1, 16'h0040, 16'hAAAA});
        dm_cmd.push_back('{1'b0, 16'h0040, 16'h0});
        dm_cmd.push_back('{1'b1, 16'h0041, 16'hBBBB});
        dm_cmd.push_back('{1'b0, 16'h0041, 16'h0});
        if_cmd.push_back(16'h0050);
        if_cmd.push_back(16'h0052);
        drain("starvation", 120);

        // Timeout: memory silent, err rises with a zero-data done.
        sync();
        chk("err_before_timeout", 32'(bus.err), 32'd0);
        mute = 1;
        to_armed = 1;
        exp_ops.push_back('{1'b0, 16'h0060, 16'h0});
        exp_rsp.push_back('{1'b0, 1'b0, 16'h0, 1'b1});
        if_cmd.push_back(16'h0060);
        drain("timeout", 60);
        mute = 0;
        to_armed = 0;
        chk("err_after_timeout", 32'(bus.err), 32'd1);
        exp_ops.push_back('{1'b0, 16'h0041, 16'h0});
        exp_rsp.push_back('{1'b1, 1'b0, 16'hBBBB, 1'b0});
        dm_cmd.push_back('{1'b0, 16'h0041, 16'h0});
        drain("after_timeout", 60);
        chk("err_sticky", 32'(bus.err), 32'd1);

        // Reset while waiting, then a stray mem_done.
        sync();
        mute = 1;
        exp_ops.push_back('{1'b0, 16'h0040, 16'h0});
        dm_cmd.push_back('{1'b0, 16'h0040, 16'h0});
        c0 = en_count;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            sync();
            if (en_count != c0) begin
                seen = 1;
                break;
            end
        end
        chk("rst_wait_issue", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        flush_agents();
        @(negedge clk);
        rst = 1'b0;
        model_dm = 16'h0;
        bus.mem_rdata = 16'hDEAD;
        stray = 1;
        @(negedge clk);
        stray = 0;
        mute = 0;
        repeat (2) sync();
        chk_idle_outputs("post_rst");
        exp_ops.push_back('{1'b0, 16'h0010, 16'h0});
        exp_rsp.push_back('{1'b0, 1'b0, 16'hC0DE, 1'b0});
        if_cmd.push_back(16'h0010);
        drain("after_rst", 60);

        // Load with halt in the same cycle: load, then one dump, then frozen.
        sync();
        exp_ops.push_back('{1'b0, 16'h0052, 16'h0});
        exp_rsp.push_back('{1'b1, 1'b0, 16'h5252, 1'b0});
        dm_cmd.push_back('{1'b0, 16'h0052, 16'h0});
        @(negedge clk);
        bus.halt_req = 1'b1;
        drain("halt_load", 60);
        for (int i = 0; i < 10 && dump_count == 0; i++) sync();
        chk("dump_count", 32'(dump_count), 32'd1);
        chk("dump_after_load", 32'(dump_cyc), 32'(dm_done_cyc + 2));
        sync();
        chk("halted", 32'(bus.halted), 32'd1);
        c0 = en_count;
        if_cmd.push_back(16'h0010);
        dm_cmd.push_back('{1'b1, 16'h0030, 16'h5555});
        repeat (20) sync();
        chk("halted_no_mem_en", 32'(en_count), 32'(c0));
        chk("halted_held", 32'(bus.halted), 32'd1);
        chk("single_dump", 32'(dump_count), 32'd1);
        @(negedge clk);
        flush_agents();
        bus.halt_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sync();
        chk("halt_cleared", 32'(bus.halted), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
